iic_arbiter: RTL and testbench

Round-robin arbiter that shares the single `iic_dri` I2C master among up to four configuration/status requesters (MS7200 RX init, MS7210 TX init, runtime pollers). It sits between the chip-control state machines and `iic_dri`. It latches one requester's transaction, issues the trigger, and tracks `iic_dri` busy/byte_over to completion. It routes read data and a completion pulse back to the granted requester only.

---
 rtl/iic_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_iic_arbiter.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_arbiter.sv
// -----------------------------------------------------------------------------
// iic_arbiter
//
// Round-robin arbiter sharing one iic_dri I2C master among NUM_REQ (2..4)
// configuration/status requesters. It latches the winning requester's
// transaction, pulses the trigger, follows iic_dri busy/byte_over to
// completion, and returns read data plus a completion pulse to the winner only.
//
// Optional feature macro: IIC_ARB_TIMEOUT_EN
//   Defined   -> a 16-bit watchdog bounds WAIT_START (START_TO cycles) and
//                WAIT_END (XFER_TO cycles); expiry forces DONE with err pulsed.
//   Undefined -> no watchdog, err tied low, the FSM waits indefinitely.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req               per-requester request level
//   req_dev_id        8-bit device slot per requester, k in [8k+7:8k]
//   req_w_r           per-requester direction, 1 = write, 0 = read
//   req_addr          16-bit register address per requester
//   req_wdata         8-bit write data per requester
//   gnt               one-hot grant level, ISSUE through DONE
//   done              one-cycle completion pulse to the granted requester
//   err               one-cycle timeout pulse, coincident with done
//   rdata             last byte read, valid with done on a read
//   iic_device_id, iic_trig, iic_w_r, iic_addr, iic_data_in   to iic_dri
//   iic_busy, iic_byte_over, iic_data_out                     from iic_dri
// -----------------------------------------------------------------------------
module iic_arbiter #(
    parameter int          NUM_REQ  = 3,
    parameter logic [15:0] START_TO = 16'd64,
    parameter logic [15:0] XFER_TO  = 16'd20000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_dev_id,
    input  logic [NUM_REQ-1:0]     req_w_r,
    input  logic [NUM_REQ*16-1:0]  req_addr,
    input  logic [NUM_REQ*8-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [7:0]             rdata,
    output logic [7:0]             iic_device_id,
    output logic                   iic_trig,
    output logic                   iic_w_r,
    output logic [15:0]            iic_addr,
    output logic [7:0]             iic_data_in,
    input  logic                   iic_busy,
    input  logic                   iic_byte_over,
    input  logic [7:0]             iic_data_out
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_END,
        DONE
    } state_e;

    state_e               state_q;
    idx_t                 last_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [7:0]           rdata_q;
    logic [7:0]           dev_id_q;
    logic                 trig_q;
    logic                 w_r_q;
    logic [15:0]          addr_q;
    logic [7:0]           wdata_q;

    // Next-grant selection, only consumed in IDLE.
    logic                 req_any;
    idx_t                 last_d;
    logic [NUM_REQ-1:0]   gnt_d;
    logic [7:0]           dev_id_d;
    logic                 w_r_d;
    logic [15:0]          addr_d;
    logic [7:0]           wdata_d;

    // Read data is only captured for reads; writes leave rdata untouched.
    logic                 rd_capture;

    function automatic int wrap_idx(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // Rotating priority: search upward from last_q+1, wrapping at NUM_REQ.
    // The inner loop keeps every vector index a constant after unrolling.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the block leaves it unassigned and infers a latch.
        req_any  = 1'b0;
        last_d   = last_q;
        gnt_d    = '0;
        dev_id_d = '0;
        w_r_d    = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!req_any && req[k] && (k == wrap_idx(int'(last_q) + off))) begin
                    req_any  = 1'b1;
                    last_d   = idx_t'(k);
                    gnt_d[k] = 1'b1;
                    dev_id_d = req_dev_id[8*k +: 8];
                    w_r_d    = req_w_r[k];
                    addr_d   = req_addr[16*k +: 16];
                    wdata_d  = req_wdata[8*k +: 8];
                end
            end
        end
    end

    assign rd_capture = iic_byte_over && !w_r_q;

`ifdef IIC_ARB_TIMEOUT_EN
    logic [NUM_REQ-1:0]   err_q;
    logic [15:0]          cnt_q;
`endif

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= idx_t'(NUM_REQ - 1);
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            dev_id_q <= 8'h00;
            trig_q   <= 1'b0;
            w_r_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef IIC_ARB_TIMEOUT_EN
            err_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            // Single-cycle pulses default low.
            trig_q <= 1'b0;
            done_q <= '0;
`ifdef IIC_ARB_TIMEOUT_EN
            err_q  <= '0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (req_any) begin
                        gnt_q    <= gnt_d;
                        last_q   <= last_d;
                        dev_id_q <= dev_id_d;
                        w_r_q    <= w_r_d;
                        addr_q   <= addr_d;
                        wdata_q  <= wdata_d;
                        trig_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end

                ISSUE: begin
`ifdef IIC_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= WAIT_START;
                end

                WAIT_START: begin
                    if (iic_busy) begin
`ifdef IIC_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                        state_q <= WAIT_END;
                    end
`ifdef IIC_ARB_TIMEOUT_EN
                    // cnt_q holds the number of WAIT_START cycles already
                    // spent, so this fires in the START_TO-th cycle.
                    else if (cnt_q >= START_TO - 16'd1) begin
                        done_q  <= gnt_q;
                        err_q   <= gnt_q;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + 16'd1;
                    end
`endif
                end

                WAIT_END: begin
                    if (!iic_busy) begin
                        if (rd_capture) begin
                            rdata_q <= iic_data_out;
                        end
                        done_q  <= gnt_q;
                        state_q <= DONE;
                    end
`ifdef IIC_ARB_TIMEOUT_EN
                    // A timed-out transfer must not publish a partial byte.
                    else if (cnt_q >= XFER_TO - 16'd1) begin
                        done_q  <= gnt_q;
                        err_q   <= gnt_q;
                        state_q <= DONE;
                    end
`endif
                    else begin
                        if (rd_capture) begin
                            rdata_q <= iic_data_out;
                        end
`ifdef IIC_ARB_TIMEOUT_EN
                        cnt_q   <= cnt_q + 16'd1;
`endif
                    end
                end

                DONE: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end

                default: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef IIC_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = '0;

    // The limits only matter when the watchdog is built.
    logic unused_timeouts;
    assign unused_timeouts = ^{START_TO, XFER_TO};
`endif

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign rdata         = rdata_q;
    assign iic_device_id = dev_id_q;
    assign iic_trig      = trig_q;
    assign iic_w_r       = w_r_q;
    assign iic_addr      = addr_q;
    assign iic_data_in   = wdata_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iic_arbiter
//
// Self-checking bench for iic_arbiter (NUM_REQ = 3). A transaction-level model
// predicts gnt/done/err/iic_trig/rdata and the latched payload every cycle; a
// simple iic_dri bus model answers each trigger with a programmable start
// latency, busy length and read byte. Directed scenarios add literal checks
// on grant order, payload values, read data and timing.
// -----------------------------------------------------------------------------
module tb_iic_arbiter;

    localparam int          NUM_REQ  = 3;
    localparam logic [15:0] START_TO = 16'd64;
    localparam logic [15:0] XFER_TO  = 16'd20000;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*8-1:0]   req_dev_id;
    logic [NUM_REQ-1:0]     req_w_r;
    logic [NUM_REQ*16-1:0]  req_addr;
    logic [NUM_REQ*8-1:0]   req_wdata;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     done;
    logic [NUM_REQ-1:0]     err;
    logic [7:0]             rdata;
    logic [7:0]             iic_device_id;
    logic                   iic_trig;
    logic                   iic_w_r;
    logic [15:0]            iic_addr;
    logic [7:0]             iic_data_in;
    logic                   iic_busy;
    logic                   iic_byte_over;
    logic [7:0]             iic_data_out;

    iic_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .START_TO (START_TO),
        .XFER_TO  (XFER_TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_dev_id    (req_dev_id),
        .req_w_r       (req_w_r),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .gnt           (gnt),
        .done          (done),
        .err           (err),
        .rdata         (rdata),
        .iic_device_id (iic_device_id),
        .iic_trig      (iic_trig),
        .iic_w_r       (iic_w_r),
        .iic_addr      (iic_addr),
        .iic_data_in   (iic_data_in),
        .iic_busy      (iic_busy),
        .iic_byte_over (iic_byte_over),
        .iic_data_out  (iic_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [7:0]  dev;
        logic        w_r;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } pay_t;

    int         m_owner;      // -1 when no transaction is granted
    int         m_last;
    int         m_wait;       // cycles spent waiting in the current phase
    bit         m_trig;
    bit         m_busy_seen;
    bit         m_done;
    bit         m_err;
    logic [7:0] m_rdata;
    pay_t       m_pay;

    function automatic pay_t req_payload(input int k);
        pay_t p;
        p.dev   = req_dev_id[8*k +: 8];
        p.w_r   = req_w_r[k];
        p.addr  = req_addr[16*k +: 16];
        p.wdata = req_wdata[8*k +: 8];
        return p;
    endfunction

    function automatic logic [NUM_REQ-1:0] owner_vec(input bit en);
        logic [NUM_REQ-1:0] v;
        v = '0;
        if (en && m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_owner     = -1;
        m_last      = NUM_REQ - 1;
        m_wait      = 0;
        m_trig      = 0;
        m_busy_seen = 0;
        m_done      = 0;
        m_err       = 0;
        m_rdata     = 8'h00;
        m_pay       = '0;
    endtask

    // Advances the model by one clock using the inputs present at the edge;
    // afterwards the m_* fields describe the outputs of the following cycle.
    task automatic model_step();
        int k;
        if (m_done) begin
            m_done  = 0;
            m_err   = 0;
            m_owner = -1;
            return;
        end
        if (m_owner < 0) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                k = (m_last + off) % NUM_REQ;
                if (req[k]) begin
                    m_owner     = k;
                    m_last      = k;
                    m_pay       = req_payload(k);
                    m_trig      = 1;
                    m_busy_seen = 0;
                    m_wait      = 0;
                    break;
                end
            end
            return;
        end
        if (m_trig) begin
            m_trig = 0;
            return;
        end
        if (!m_busy_seen) begin
            if (iic_busy) begin
                m_busy_seen = 1;
                m_wait      = 0;
            end
`ifdef IIC_ARB_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait >= int'(START_TO)) begin
                    m_done = 1;
                    m_err  = 1;
                end
            end
`endif
            return;
        end
        if (!iic_busy) begin
            if (iic_byte_over && !m_pay.w_r) m_rdata = iic_data_out;
            m_done = 1;
            return;
        end
`ifdef IIC_ARB_TIMEOUT_EN
        m_wait++;
        if (m_wait >= int'(XFER_TO)) begin
            m_done = 1;
            m_err  = 1;
            return;
        end
`endif
        if (iic_byte_over && !m_pay.w_r) m_rdata = iic_data_out;
    endtask

    // ------------------------------------------------------------------------
    // Monitor / compare process
    // ------------------------------------------------------------------------
    int gq[$];                 // requester index per observed trigger
    int trig_cnt;
    int done_cnt[NUM_REQ];
    int last_trig_cyc;
    int last_done_cyc;

    task automatic clear_logs();
        gq.delete();
        trig_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) done_cnt[i] = 0;
    endtask

    initial begin
        model_reset();
        clear_logs();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            check("gnt",      gnt,      owner_vec(1'b1));
            check("done",     done,     owner_vec(m_done));
            check("err",      err,      owner_vec(m_err));
            check("iic_trig", iic_trig, m_trig);
            check("rdata",    rdata,    m_rdata);
            if (m_owner >= 0)
                check("payload", {iic_device_id, iic_w_r, iic_addr, iic_data_in}, m_pay);
            if (iic_trig) begin
                trig_cnt++;
                last_trig_cyc = cyc;
                for (int i = 0; i < NUM_REQ; i++)
                    if (gnt[i]) gq.push_back(i);
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (done[i]) begin
                    done_cnt[i]++;
                    last_done_cyc = cyc;
                end
        end
    end

    // ------------------------------------------------------------------------
    // iic_dri bus model: busy rises bus_lat cycles after the trigger, stays
    // high for bus_len cycles, and byte_over carries bus_data in its last cycle.
    // ------------------------------------------------------------------------
    int         bus_lat;
    int         bus_len;
    logic [7:0] bus_data;
    bit         bus_never;
    int         bm_phase;
    int         bm_cnt;

    initial begin
        iic_busy      = 1'b0;
        iic_byte_over = 1'b0;
        iic_data_out  = 8'h00;
        bm_phase      = 0;
        bm_cnt        = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                iic_busy      = 1'b0;
                iic_byte_over = 1'b0;
                bm_phase      = 0;
            end else begin
                case (bm_phase)
                    0: begin
                        iic_byte_over = 1'b0;
                        if (iic_trig && !bus_never) begin
                            bm_phase = 1;
                            bm_cnt   = bus_lat;
                        end
                    end
                    1: begin
                        if (bm_cnt <= 1) begin
                            iic_busy = 1'b1;
                            bm_phase = 2;
                            bm_cnt   = bus_len;
                        end else begin
                            bm_cnt--;
                        end
                    end
                    default: begin
                        bm_cnt--;
                        if (bm_cnt == 1) begin
                            iic_byte_over = 1'b1;
                            iic_data_out  = bus_data;
                        end else if (bm_cnt <= 0) begin
                            iic_busy      = 1'b0;
                            iic_byte_over = 1'b0;
                            bm_phase      = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic set_req(input int k, input logic [7:0] dev, input logic wr,
                           input logic [15:0] addr, input logic [7:0] wd);
        req_dev_id[8*k +: 8]  = dev;
        req_w_r[k]            = wr;
        req_addr[16*k +: 16]  = addr;
        req_wdata[8*k +: 8]   = wd;
        req[k]                = 1'b1;
    endtask

    task automatic wait_trig(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (iic_trig) ok = 1;
        end
        check(name, ok, 1'b1);
    endtask

    task automatic wait_done(input string name, input int k, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done[k]) ok = 1;
        end
        check(name, ok, 1'b1);
    endtask

    task automatic wait_busy(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (iic_busy) ok = 1;
        end
        check(name, ok, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        rst_n      = 1'b0;
        req        = '0;
        req_w_r    = '0;
        req_dev_id = '0;
        req_addr   = '0;
        req_wdata  = '0;
        bus_lat    = 2;
        bus_len    = 40;
        bus_data   = 8'h00;
        bus_never  = 0;

        repeat (3) @(negedge clk);
        check("reset gnt",      gnt,           3'b000);
        check("reset done",     done,          3'b000);
        check("reset trig",     iic_trig,      1'b0);
        check("reset rdata",    rdata,         8'h00);
        check("reset dev_id",   iic_device_id, 8'h00);
        check("reset addr",     iic_addr,      16'h0000);
        rst_n = 1'b1;

        // Single write from requester 0.
        @(negedge clk);
        set_req(0, 8'hB2, 1'b1, 16'h1234, 8'h5A);
        wait_trig("t1 trig seen", 10);
        check("t1 gnt",    gnt,           3'b001);
        check("t1 dev_id", iic_device_id, 8'hB2);
        check("t1 w_r",    iic_w_r,       1'b1);
        check("t1 addr",   iic_addr,      16'h1234);
        check("t1 wdata",  iic_data_in,   8'h5A);
        wait_done("t1 done seen", 0, 200);
        req[0] = 1'b0;
        check("t1 gnt at done", gnt, 3'b001);
        @(negedge clk);
        check("t1 gnt dropped",  gnt,         3'b000);
        check("t1 done count",   done_cnt[0], 1);
        check("t1 trig count",   trig_cnt,    1);

        // Read return on requester 1, then a write that must not touch rdata.
        bus_len  = 6;
        bus_data = 8'hA7;
        set_req(1, 8'h56, 1'b0, 16'h0003, 8'h00);
        wait_done("t2 read done", 1, 100);
        check("t2 rdata", rdata, 8'hA7);
        req[1] = 1'b0;
        @(negedge clk);
        bus_data = 8'h11;
        set_req(0, 8'hB2, 1'b1, 16'h0020, 8'h33);
        wait_done("t2 write done", 0, 100);
        req[0] = 1'b0;
        @(negedge clk);
        check("t2 rdata after write", rdata, 8'hA7);

        // Fairness with all three requests held.
        apply_reset();
        bus_lat = 1;
        bus_len = 4;
        set_req(0, 8'h20, 1'b1, 16'h0100, 8'h01);
        set_req(1, 8'h22, 1'b0, 16'h0200, 8'h02);
        set_req(2, 8'h24, 1'b1, 16'h0300, 8'h03);
        for (int i = 0; i < 300 && gq.size() < 6; i++) @(negedge clk);
        req = '0;
        repeat (30) @(negedge clk);
        check("t3 grant total", gq.size(), 6);
        if (gq.size() >= 6) begin
            check("t3 grant 0", gq[0], 0);
            check("t3 grant 1", gq[1], 1);
            check("t3 grant 2", gq[2], 2);
            check("t3 grant 3", gq[3], 0);
            check("t3 grant 4", gq[4], 1);
            check("t3 grant 5", gq[5], 2);
        end

        // Payload isolation: requester 2 changes its inputs and drops req.
        bus_len = 20;
        set_req(2, 8'h40, 1'b1, 16'h0010, 8'h77);
        wait_trig("t4 trig seen", 10);
        wait_busy("t4 busy seen", 20);
        repeat (2) @(negedge clk);
        req_addr[47:32] = 16'hFFFF;
        req[2]          = 1'b0;
        @(negedge clk);
        check("t4 addr held", iic_addr, 16'h0010);
        wait_done("t4 done seen", 2, 100);
        check("t4 addr at done", iic_addr, 16'h0010);

        // Bus never answers.
        apply_reset();
        bus_never = 1;
        set_req(0, 8'h60, 1'b1, 16'h0040, 8'h44);
        set_req(1, 8'h62, 1'b1, 16'h0041, 8'h45);
`ifdef IIC_ARB_TIMEOUT_EN
        wait_done("t5 timeout done", 0, 150);
        check("t5 err", err, 3'b001);
        check("t5 latency", last_done_cyc - last_trig_cyc, 65);
        req[0]    = 1'b0;
        bus_never = 0;
        bus_len   = 5;
        wait_trig("t5 next trig", 10);
        check("t5 next gnt", gnt, 3'b010);
        wait_done("t5 next done", 1, 100);
        req[1] = 1'b0;
`else
        repeat (200) @(negedge clk);
        check("t5 gnt stuck",   gnt,         3'b001);
        check("t5 no done",     done_cnt[0], 0);
        check("t5 single trig", trig_cnt,    1);
        req = '0;
`endif

        // Asynchronous reset during WAIT_END.
        apply_reset();
        bus_never = 0;
        bus_len   = 40;
        set_req(1, 8'h70, 1'b1, 16'h0ABC, 8'h99);
        wait_busy("t6 busy seen", 20);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 gnt in reset",  gnt,      3'b000);
        check("t6 trig in reset", iic_trig, 1'b0);
        check("t6 addr in reset", iic_addr, 16'h0000);
        req = '0;
        set_req(0, 8'h72, 1'b1, 16'h0DEF, 8'h98);
        set_req(1, 8'h70, 1'b1, 16'h0ABC, 8'h99);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_trig("t6 trig after reset", 10);
        check("t6 first gnt", gnt, 3'b001);
        wait_done("t6 done", 0, 100);
        req = '0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end of the scenarios");
        $fatal(1);
    end

endmodule
